// File: rtl/adpll_cfg_regs_if.sv
// ADPLL parameter programming bus.
// The host (master) drives a session enable, a parameter select and write data,
// and picks the readback source. The register bank (slave) returns the active
// parameter set, commit/error status and registered readback data.
// `prog` carries the session-enable ("program") signal; `program` itself is a
// reserved word in SystemVerilog and cannot be used as a signal name.
interface adpll_cfg_regs_if #(
  parameter int unsigned W = 5
);
  logic         clr;
  logic         prog;
  logic [2:0]   param_sel;
  logic [W-1:0] pgm_value;
  logic         out_sel;

  logic [W-1:0] ndiv;
  logic [W-1:0] alpha_var;
  logic [W-1:0] beta_var;
  logic [W-1:0] dco_offset;
  logic [W-1:0] dco_threshold;
  logic [W-1:0] kdco;
  logic         cfg_update;
  logic         cfg_err;
  logic         busy;
  logic [W-1:0] dout;

  modport master (
    output clr, prog, param_sel, pgm_value, out_sel,
    input  ndiv, alpha_var, beta_var, dco_offset, dco_threshold, kdco,
    input  cfg_update, cfg_err, busy, dout
  );

  modport slave (
    input  clr, prog, param_sel, pgm_value, out_sel,
    output ndiv, alpha_var, beta_var, dco_offset, dco_threshold, kdco,
    output cfg_update, cfg_err, busy, dout
  );
endinterface

// File: rtl/adpll_cfg_regs.sv
// ADPLL configuration register bank.
// Parameter writes land in shadow registers during a programming session.
// When the session ends the full shadow set is validated and either copied
// to the active registers in a single edge or discarded (shadow reloaded
// from active). Readback of shadow or active values is registered.
//
// Register index: 0 ndiv, 1 alpha_var, 2 beta_var, 3 dco_offset,
//                 4 dco_threshold, 5 kdco; selects 6/7 are illegal.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no session; prog high starts one and takes that cycle's write
// S_LOAD  | session open; each prog-high cycle writes one shadow register
// S_CHECK | one cycle: validate shadow set, commit or discard
module adpll_cfg_regs #(
  parameter int unsigned W          = 5,
  parameter int unsigned DEF_NDIV   = 0,
  parameter int unsigned DEF_ALPHA  = 2,
  parameter int unsigned DEF_BETA   = 3,
  parameter int unsigned DEF_OFFSET = 8,
  parameter int unsigned DEF_THRESH = 12,
  parameter int unsigned DEF_KDCO   = 1
) (
  input logic              i_clk,
  input logic              i_rst,
  adpll_cfg_regs_if.slave  bus
);

  typedef logic [W-1:0] val_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  localparam int unsigned IDX_OFFSET = 3;
  localparam int unsigned IDX_THRESH = 4;
  localparam int unsigned IDX_KDCO   = 5;

  localparam val_t DEFS [6] = '{
    val_t'(DEF_NDIV), val_t'(DEF_ALPHA), val_t'(DEF_BETA),
    val_t'(DEF_OFFSET), val_t'(DEF_THRESH), val_t'(DEF_KDCO)
  };

  state_t r_state;
  logic   r_busy;
  val_t   r_shd [6];
  val_t   r_act [6];
  logic   r_bad;
  logic   r_upd;
  logic   r_err;
  val_t   r_dout;

  state_t w_next;
  logic   w_sel_ok;
  logic   w_write;
  logic   w_set_bad;
  logic   w_commit;
  logic   w_reject;
  logic   w_set_ok;
  val_t   w_rd;

  assign w_sel_ok = (bus.param_sel <= 3'd5);

  // A session is acceptable only if no illegal select was seen, the DCO
  // threshold sits strictly above the offset, and the DCO gain is non-zero.
  assign w_set_ok = !r_bad
                 && (r_shd[IDX_THRESH] > r_shd[IDX_OFFSET])
                 && (r_shd[IDX_KDCO] != '0);

  // State register; busy is registered alongside so it never glitches.
  always_ff @(posedge i_clk) begin
    if (!i_rst || bus.clr) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    w_next    = r_state;
    w_write   = 1'b0;
    w_set_bad = 1'b0;
    w_commit  = 1'b0;
    w_reject  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.prog) begin
          w_next    = S_LOAD;
          w_write   = w_sel_ok;
          w_set_bad = !w_sel_ok;
        end
      end
      S_LOAD: begin
        if (bus.prog) begin
          w_write   = w_sel_ok;
          w_set_bad = !w_sel_ok;
        end else begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        w_next   = S_IDLE;
        w_commit = w_set_ok;
        w_reject = !w_set_ok;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shadow/active registers, session-bad flag and status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst || bus.clr) begin
      r_shd <= DEFS;
      r_act <= DEFS;
      r_bad <= 1'b0;
      r_upd <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_upd <= w_commit;
      if (w_write) begin
        r_shd[bus.param_sel] <= bus.pgm_value;
      end
      if (w_set_bad) begin
        r_bad <= 1'b1;
      end
      if (w_commit) begin
        r_act <= r_shd;
        r_err <= 1'b0;
        r_bad <= 1'b0;
      end
      if (w_reject) begin
        r_shd <= r_act;
        r_err <= 1'b1;
        r_bad <= 1'b0;
      end
    end
  end

  // Readback source mux; illegal selects read as zero.
  always_comb begin
    w_rd = '0;
    if (w_sel_ok) begin
      w_rd = bus.out_sel ? r_shd[bus.param_sel] : r_act[bus.param_sel];
    end
  end

  // Registered readback; keeps tracking through clr, only reset zeroes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_dout <= '0;
    end else begin
      r_dout <= w_rd;
    end
  end

  assign bus.ndiv          = r_act[0];
  assign bus.alpha_var     = r_act[1];
  assign bus.beta_var      = r_act[2];
  assign bus.dco_offset    = r_act[IDX_OFFSET];
  assign bus.dco_threshold = r_act[IDX_THRESH];
  assign bus.kdco          = r_act[IDX_KDCO];
  assign bus.cfg_update    = r_upd;
  assign bus.cfg_err       = r_err;
  assign bus.busy          = r_busy;
  assign bus.dout          = r_dout;

endmodule

// File: tb/tb_adpll_cfg_regs.sv
// Directed bench for the ADPLL configuration register bank.
module tb_adpll_cfg_regs;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int busy_cnt;
  int upd_cnt;

  adpll_cfg_regs_if #(.W(W)) bus ();

  adpll_cfg_regs #(.W(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_mon();
    tick();
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.cfg_update === 1'b1) upd_cnt++;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [W-1:0] val);
    bus.prog      = 1'b1;
    bus.param_sel = sel;
    bus.pgm_value = val;
    tick();
  endtask

  // Drop prog, pass through CHECK, land back in IDLE.
  task automatic end_session();
    bus.prog = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    bus.clr       = 1'b0;
    bus.prog      = 1'b0;
    bus.param_sel = 3'd0;
    bus.pgm_value = '0;
    bus.out_sel   = 1'b0;

    // Reset for 3 cycles, then release
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_ndiv",   bus.ndiv,          0);
    chk("rst_alpha",  bus.alpha_var,     2);
    chk("rst_beta",   bus.beta_var,      3);
    chk("rst_offset", bus.dco_offset,    8);
    chk("rst_thresh", bus.dco_threshold, 12);
    chk("rst_kdco",   bus.kdco,          1);
    chk("rst_busy",   bus.busy,          0);
    chk("rst_err",    bus.cfg_err,       0);
    chk("rst_upd",    bus.cfg_update,    0);
    chk("rst_dout",   bus.dout,          0);

    // Session A: full default set, count busy and update cycles
    busy_cnt = 0;
    upd_cnt  = 0;
    bus.prog = 1'b1;
    bus.param_sel = 3'd0; bus.pgm_value = 5'd0;  tick_mon();
    bus.param_sel = 3'd1; bus.pgm_value = 5'd2;  tick_mon();
    bus.param_sel = 3'd2; bus.pgm_value = 5'd3;  tick_mon();
    bus.param_sel = 3'd3; bus.pgm_value = 5'd8;  tick_mon();
    bus.param_sel = 3'd4; bus.pgm_value = 5'd12; tick_mon();
    bus.param_sel = 3'd5; bus.pgm_value = 5'd1;  tick_mon();
    bus.prog = 1'b0;
    tick_mon();
    chk("a_upd_before_check", bus.cfg_update, 0);
    tick_mon();
    chk("a_upd_pulse", bus.cfg_update, 1);
    tick_mon(); tick_mon();
    chk("a_busy_cycles", busy_cnt, 7);
    chk("a_upd_count",   upd_cnt,  1);
    chk("a_err",         bus.cfg_err, 0);

    bus.out_sel = 1'b0; bus.param_sel = 3'd4;
    tick();
    chk("a_rd_thresh", bus.dout, 12);
    bus.param_sel = 3'd6;
    tick();
    chk("rd_sel6_zero", bus.dout, 0);

    // Session C: illegal select plus alpha=7 -> rejected
    wr(3'd6, 5'd0);
    wr(3'd1, 5'd7);
    end_session();
    chk("c_upd",   bus.cfg_update, 0);
    chk("c_err",   bus.cfg_err,    1);
    chk("c_alpha", bus.alpha_var,  2);

    // Valid session: ndiv=4, alpha=7 -> commit, error cleared
    wr(3'd0, 5'd4);
    wr(3'd1, 5'd7);
    end_session();
    chk("v_upd",    bus.cfg_update, 1);
    chk("v_err",    bus.cfg_err,    0);
    chk("v_ndiv",   bus.ndiv,       4);
    chk("v_alpha",  bus.alpha_var,  7);
    chk("v_thresh", bus.dco_threshold, 12);
    tick();
    chk("v_upd_one_cycle", bus.cfg_update, 0);

    // Session B: offset=15 >= thresh=12 -> rejected, shadow restored
    bus.out_sel = 1'b1;
    wr(3'd3, 5'd15);
    bus.prog = 1'b0;
    tick();
    chk("b_shadow_15", bus.dout, 15);
    tick();
    chk("b_upd",    bus.cfg_update, 0);
    chk("b_err",    bus.cfg_err,    1);
    chk("b_offset", bus.dco_offset, 8);
    tick();
    chk("b_shadow_restored", bus.dout, 8);

    // Session E: readback during LOAD, then clr mid-session
    wr(3'd2, 5'd9);
    bus.out_sel = 1'b1;
    wr(3'd2, 5'd9);
    chk("e_rd_shadow", bus.dout, 9);
    bus.out_sel = 1'b0;
    wr(3'd2, 5'd9);
    chk("e_rd_active", bus.dout, 3);
    chk("e_busy",      bus.busy, 1);
    bus.prog = 1'b0;
    bus.clr  = 1'b1;
    tick();
    chk("e_clr_busy",  bus.busy,       0);
    chk("e_clr_ndiv",  bus.ndiv,       0);
    chk("e_clr_alpha", bus.alpha_var,  2);
    chk("e_clr_err",   bus.cfg_err,    0);
    chk("e_clr_upd",   bus.cfg_update, 0);
    bus.clr     = 1'b0;
    bus.out_sel = 1'b1;
    bus.param_sel = 3'd2;
    tick();
    chk("e_clr_shadow_beta", bus.dout, 3);
    tick();
    chk("e_after_upd",  bus.cfg_update, 0);
    chk("e_after_busy", bus.busy,       0);

    // Session F: reset and clr together during CHECK with a valid set
    wr(3'd0, 5'd5);
    wr(3'd1, 5'd9);
    bus.prog = 1'b0;
    tick();
    chk("f_in_check", bus.busy, 1);
    rst     = 1'b0;
    bus.clr = 1'b1;
    tick();
    chk("f_upd",   bus.cfg_update, 0);
    chk("f_ndiv",  bus.ndiv,       0);
    chk("f_alpha", bus.alpha_var,  2);
    chk("f_busy",  bus.busy,       0);
    chk("f_dout",  bus.dout,       0);
    rst     = 1'b1;
    bus.clr = 1'b0;
    tick();
    chk("f_post_upd",  bus.cfg_update, 0);
    chk("f_post_ndiv", bus.ndiv,       0);
    chk("f_post_err",  bus.cfg_err,    0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
